id_ex_stage: RTL and testbench

- ID/EX pipeline boundary directly downstream of the decode-stage controller in the 5-stage RV32I core.
- Registers decoded control (RegWrite, ResultSrc, MemWrite, Jump, Beq/Bne/Blt/Bge, ALUControl, ALUSrc) together with register operands, immediate, PC and register indices into the execute stage.
- Provides stall (hold) and flush (bubble insert) from the hazard unit.
- Owns halt sequencing: captures the decoder's `done` flag and drains the pipeline before asserting a sticky halted flag.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/pipe_reg.sv | 19 +
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: writeback/ALU encodings, ID/EX control bundle, halt drain default.
package core_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned CTRL_W           = 15;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_LUI = 3'b100,
    ALU_SLT = 3'b101,
    ALU_XOR = 3'b111
  } alu_ctrl_e;

  // Decoded control carried across ID/EX; a bubble is the all-zero value.
  typedef struct packed {
    logic       valid;
    logic       rsvd;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       blt;
    logic       bge;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_bundle_t;

endpackage

// File: rtl/pipe_reg.sv
// Pipeline register with synchronous active-low reset, clear (bubble) and enable (hold when low).
module pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary with stall/flush and halt drain sequencing.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic            BeqD,
  input  logic            BneD,
  input  logic            BltD,
  input  logic            BgeD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic            doneD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic            BeqE,
  output logic            BneE,
  output logic            BltE,
  output logic            BgeE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE,
  output logic            HaltPendingE,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]     BubbleCountE,
`endif
  output logic            HaltedE
);

  localparam int unsigned CNT_W  = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned DATA_W = 5 * XLEN + 15;

  if (DRAIN_CYCLES == 0) begin : g_bad_drain
    $error("id_ex_stage: DRAIN_CYCLES must be at least 1");
  end

  // One bit per state so the halt flags come straight off flops.
  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_DRAIN  = 2'b01,
    S_HALTED = 2'b10
  } halt_state_e;

  halt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble;
  ctrl_bundle_t     ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic             unused_rsvd;

  // Post-halt fetches and the done instruction itself never enter EX.
  assign bubble = FlushE | (~StallE & ((state_q != S_RUN) | doneD));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!StallE) begin
      case (state_q)
        S_RUN: begin
          if (doneD && !FlushE) begin
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_HALTED;
        end
        default: ;
      endcase
    end
  end

  assign HaltPendingE = state_q[0];
  assign HaltedE      = state_q[1];

  always_comb begin
    ctrl_d             = '0;
    ctrl_d.valid       = 1'b1;
    ctrl_d.reg_write   = RegWriteD;
    ctrl_d.result_src  = ResultSrcD;
    ctrl_d.mem_write   = MemWriteD;
    ctrl_d.jump        = JumpD;
    ctrl_d.beq         = BeqD;
    ctrl_d.bne         = BneD;
    ctrl_d.blt         = BltD;
    ctrl_d.bge         = BgeD;
    ctrl_d.alu_control = ALUControlD;
    ctrl_d.alu_src     = ALUSrcD;
  end

  pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (~StallE),
    .clr (bubble),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (~StallE),
    .clr (bubble),
    .d   ({RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD}),
    .q   (data_q)
  );

  assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = data_q;

  assign ValidE      = ctrl_q.valid;
  assign RegWriteE   = ctrl_q.reg_write;
  assign ResultSrcE  = ctrl_q.result_src;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BeqE        = ctrl_q.beq;
  assign BneE        = ctrl_q.bne;
  assign BltE        = ctrl_q.blt;
  assign BgeE        = ctrl_q.bge;
  assign ALUControlE = ctrl_q.alu_control;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign unused_rsvd = ctrl_q.rsvd;

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)        BubbleCountE <= '0;
    else if (bubble) BubbleCountE <= BubbleCountE + 32'd1;
  end
`else
  // Bubble counter not built.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: spec-level model checked every cycle plus literal expectations.
module tb_id_ex_stage;

  localparam int unsigned DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallE = 1'b0, FlushE = 1'b0;
  logic        RegWriteD, MemWriteD, JumpD, ALUSrcD, BeqD, BneD, BltD, BgeD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic        doneD = 1'b0;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic        RegWriteE, MemWriteE, JumpE, ALUSrcE, BeqE, BneE, BltE, BgeE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE, HaltPendingE, HaltedE;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] BubbleCountE;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  id_ex_stage #(.XLEN(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .ALUSrcD(ALUSrcD),
    .BeqD(BeqD), .BneD(BneD), .BltD(BltD), .BgeD(BgeD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .doneD(doneD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .BeqE(BeqE), .BneE(BneE), .BltE(BltE), .BgeE(BgeE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ValidE(ValidE), .HaltPendingE(HaltPendingE),
`ifdef ID_EX_BUBBLE_CNT_EN
    .BubbleCountE(BubbleCountE),
`endif
    .HaltedE(HaltedE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model of the execute slot: what the stage must hold after each edge.
  logic [12:0] m_ctrl = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0, m_pc = '0, m_pc4 = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  bit          m_pend = 1'b0, m_halt = 1'b0;
  int          m_drain = 0;
  logic [31:0] m_bcnt = '0;

  always @(posedge clk) begin
    bit bub;
    if (!rst) begin
      m_ctrl = '0; m_valid = 1'b0;
      {m_rd1, m_rd2, m_imm, m_pc, m_pc4, m_rs1, m_rs2, m_rd} = '0;
      m_pend = 1'b0; m_halt = 1'b0; m_drain = 0; m_bcnt = '0;
    end else begin
      bub = FlushE || (!StallE && (m_pend || m_halt || doneD));
      if (!StallE) begin
        if (m_pend) begin
          m_drain = m_drain - 1;
          if (m_drain == 0) begin m_pend = 1'b0; m_halt = 1'b1; end
        end else if (!m_halt && !FlushE && doneD) begin
          m_pend = 1'b1; m_drain = DRAIN;
        end
      end
      if (bub) begin
        m_ctrl = '0; m_valid = 1'b0;
        {m_rd1, m_rd2, m_imm, m_pc, m_pc4, m_rs1, m_rs2, m_rd} = '0;
        m_bcnt = m_bcnt + 32'd1;
      end else if (!StallE) begin
        m_ctrl = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BeqD, BneD, BltD, BgeD,
                  ALUControlD, ALUSrcD};
        m_valid = 1'b1;
        m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmExtD; m_pc = PCD; m_pc4 = PCPlus4D;
        m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl", 32'({RegWriteE, ResultSrcE, MemWriteE, JumpE, BeqE, BneE, BltE, BgeE,
                       ALUControlE, ALUSrcE}), 32'(m_ctrl));
      chk("valid", 32'(ValidE), 32'(m_valid));
      chk("rd1", RD1E, m_rd1);
      chk("rd2", RD2E, m_rd2);
      chk("imm", ImmExtE, m_imm);
      chk("pc", PCE, m_pc);
      chk("pc4", PCPlus4E, m_pc4);
      chk("idx", 32'({Rs1E, Rs2E, RdE}), 32'({m_rs1, m_rs2, m_rd}));
      chk("pend", 32'(HaltPendingE), 32'(m_pend));
      chk("halted", 32'(HaltedE), 32'(m_halt));
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("bcnt", BubbleCountE, m_bcnt);
`endif
    end
  end

  task automatic drive(input logic [12:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    {RegWriteD, ResultSrcD, MemWriteD, JumpD, BeqD, BneD, BltD, BgeD, ALUControlD, ALUSrcD} = c;
    RD1D = a; RD2D = b; ImmExtD = imm; PCD = pc; PCPlus4D = pc + 32'd4;
    Rs1D = s1; Rs2D = s2; RdD = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [12:0] vec_c [4];
  logic [31:0] vec_a [4];

  initial begin
    vec_c[0] = 13'b1_01_0_0_0000_000_1;  // load word
    vec_c[1] = 13'b0_00_1_0_0000_000_1;  // store
    vec_c[2] = 13'b0_00_0_0_1000_001_0;  // beq
    vec_c[3] = 13'b1_10_0_1_0000_000_0;  // jal
    vec_a[0] = 32'hDEAD_BEEF; vec_a[1] = 32'h0000_0001;
    vec_a[2] = 32'h8000_0000; vec_a[3] = 32'h7FFF_FFFF;

    // Reset with all inputs high
    drive('1, '1, '1, '1, '1, '1, '1, '1);
    doneD = 1'b1; StallE = 1'b1; FlushE = 1'b1;
    tick();
    chk("rst_valid", 32'(ValidE), 32'd0);
    chk("rst_regwrite", 32'(RegWriteE), 32'd0);
    chk("rst_rd1", RD1E, 32'd0);
    chk("rst_pend", 32'(HaltPendingE), 32'd0);
    chk("rst_halted", 32'(HaltedE), 32'd0);
    chk_en = 1'b1;
    doneD = 1'b0; StallE = 1'b0; FlushE = 1'b0;

    // ADD x3, 5, 7
    rst = 1'b1;
    drive(13'b1_00_0_0_0000_000_0, 32'd5, 32'd7, 32'd0, 32'h100, 5'd1, 5'd2, 5'd3);
    tick();
    chk("add_valid", 32'(ValidE), 32'd1);
    chk("add_rd1", RD1E, 32'd5);
    chk("add_rd2", RD2E, 32'd7);
    chk("add_rd", 32'(RdE), 32'd3);
    chk("add_pc4", PCPlus4E, 32'h104);

    // Stall holds for two cycles despite new inputs
    StallE = 1'b1;
    drive(13'b0_01_1_0_0000_011_1, 32'd99, 32'd98, 32'd97, 32'h200, 5'd9, 5'd8, 5'd7);
    tick();
    chk("stall1_rd1", RD1E, 32'd5);
    tick();
    chk("stall2_rd", 32'(RdE), 32'd3);
    chk("stall2_memwrite", 32'(MemWriteE), 32'd0);

    // Flush beats stall
    FlushE = 1'b1; MemWriteD = 1'b1;
    tick();
    chk("flush_memwrite", 32'(MemWriteE), 32'd0);
    chk("flush_valid", 32'(ValidE), 32'd0);
    FlushE = 1'b0; StallE = 1'b0;

    for (int i = 0; i < 4; i++) begin
      drive(vec_c[i], vec_a[i], ~vec_a[i], 32'(i * 4), 32'h1000 + 32'(i * 4),
            5'(i + 10), 5'(i + 20), 5'(i + 1));
      tick();
    end
    chk("vec3_jump", 32'(JumpE), 32'd1);
    chk("vec3_rd1", RD1E, 32'h7FFF_FFFF);

    // Halt without stall: captured at E0, halted after E3
    doneD = 1'b1;
    tick();
    chk("halt_e0_pend", 32'(HaltPendingE), 32'd1);
    chk("halt_e0_valid", 32'(ValidE), 32'd0);
    doneD = 1'b0;
    drive(13'b1_00_0_0_0000_000_0, 32'd1, 32'd2, 32'd3, 32'h300, 5'd1, 5'd2, 5'd4);
    tick();
    chk("halt_e1_valid", 32'(ValidE), 32'd0);
    tick();
    chk("halt_e2_halted", 32'(HaltedE), 32'd0);
    tick();
    chk("halt_e3_halted", 32'(HaltedE), 32'd1);
    chk("halt_e3_pend", 32'(HaltPendingE), 32'd0);
    tick();
    chk("post_halt_valid", 32'(ValidE), 32'd0);
    chk("post_halt_sticky", 32'(HaltedE), 32'd1);

    rst = 1'b0;
    tick();
    chk("rst2_halted", 32'(HaltedE), 32'd0);
    rst = 1'b1;

    // Flushed or stalled done must not start a halt
    doneD = 1'b1; FlushE = 1'b1;
    tick();
    chk("flushed_done_pend", 32'(HaltPendingE), 32'd0);
    FlushE = 1'b0; StallE = 1'b1;
    tick();
    chk("stalled_done_pend", 32'(HaltPendingE), 32'd0);
    StallE = 1'b0; doneD = 1'b0;
    drive(13'b1_00_0_0_0000_010_0, 32'h55, 32'hAA, 32'd0, 32'h400, 5'd5, 5'd6, 5'd7);
    tick();
    chk("after_flushed_valid", 32'(ValidE), 32'd1);
    chk("after_flushed_rd", 32'(RdE), 32'd7);

    // Halt with a one-cycle stall in the drain
    doneD = 1'b1;
    tick();
    chk("hs_e0_pend", 32'(HaltPendingE), 32'd1);
    doneD = 1'b0;
    tick();
    StallE = 1'b1;
    tick();
    chk("hs_e2_pend", 32'(HaltPendingE), 32'd1);
    StallE = 1'b0;
    tick();
    chk("hs_e3_halted", 32'(HaltedE), 32'd0);
    tick();
    chk("hs_e4_halted", 32'(HaltedE), 32'd1);

    // Reset mid-drain
    rst = 1'b0;
    tick();
    rst = 1'b1;
    doneD = 1'b1;
    tick();
    doneD = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_pend", 32'(HaltPendingE), 32'd0);
    chk("mid_rst_halted", 32'(HaltedE), 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bcnt_after_rst", BubbleCountE, 32'd0);
`endif
    rst = 1'b1; FlushE = 1'b1;
    tick();
    tick();
    FlushE = 1'b0;
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bcnt_two_flush", BubbleCountE, 32'd2);
`endif
    tick();
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
